// File: rtl/dpram_pkg.sv
// Shared types and constants for the parametrised dual-port RAM.
// Mode encodings match the RD_MODE / COLL_PRI parameter values of dpram_param.
package dpram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam int RD_FIRST = 0;
    localparam int WR_FIRST = 1;
    localparam int PRI_A    = 0;
    localparam int PRI_B    = 1;

endpackage

// File: rtl/dpram_rd_pipe.sv
// Per-port read data/valid register stage; OUT_REG adds a second pipelined stage.
// Data registers only load on valid cycles so the output holds its last read value.
module dpram_rd_pipe #(
    parameter int DW      = 8,
    parameter int OUT_REG = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [DW-1:0] data,
    output logic [DW-1:0] dout,
    output logic          valid
);

    logic [DW-1:0] d1_r;
    logic          v1_r;

    // First stage: capture read data of an accepted access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1_r <= '0;
            v1_r <= 1'b0;
        end else begin
            v1_r <= en;
            if (en) begin
                d1_r <= data;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DW-1:0] d2_r;
            logic          v2_r;

            // Second stage: delay data and valid together by one cycle
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    d2_r <= '0;
                    v2_r <= 1'b0;
                end else begin
                    v2_r <= v1_r;
                    if (v1_r) begin
                        d2_r <= d1_r;
                    end
                end
            end

            assign dout  = d2_r;
            assign valid = v2_r;
        end else begin : g_direct
            assign dout  = d1_r;
            assign valid = v1_r;
        end
    endgenerate

endmodule

// File: rtl/dpram_param.sv
// True dual-port synchronous RAM with post-reset clear sequence, write-collision
// arbitration, selectable read-during-write behaviour and per-port read valid.
module dpram_param
    import dpram_pkg::*;
#(
    parameter int DW       = 8,
    parameter int AW       = 4,
    parameter int RD_MODE  = 0,
    parameter int COLL_PRI = 0,
    parameter int OUT_REG  = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          wea,
    input  logic [AW-1:0] addra,
    input  logic [DW-1:0] dina,
    output logic [DW-1:0] douta,
    output logic          valida,
    input  logic          enb,
    input  logic          web,
    input  logic [AW-1:0] addrb,
    input  logic [DW-1:0] dinb,
    output logic [DW-1:0] doutb,
    output logic          validb,
    output logic          collision,
    output logic          init_done
);

    localparam int          DEPTH      = 2 ** AW;
    localparam logic [AW:0] LAST_PTR   = (AW + 1)'(DEPTH - 1);
    localparam logic [AW:0] PTR_ONE    = (AW + 1)'(1);
    localparam logic        B_WINS     = (COLL_PRI == PRI_B);
    localparam logic        WRITE_FRST = (RD_MODE == WR_FIRST);

    state_e        state_r, state_next_s;
    logic [AW:0]   ptr_r;
    logic          init_done_r, collision_r;
    logic [DW-1:0] mem [DEPTH];

    logic          acc_a_s, acc_b_s, wr_a_s, wr_b_s, coll_s, keep_a_s, keep_b_s;
    logic [DW-1:0] win_data_s, rd_a_s, rd_b_s;

    // Clear FSM next-state: leave CLEAR once the last location is being zeroed
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_CLEAR: begin
                if (ptr_r == LAST_PTR) begin
                    state_next_s = ST_READY;
                end else begin
                    state_next_s = ST_CLEAR;
                end
            end
            ST_READY: state_next_s = ST_READY;
            default:  state_next_s = ST_CLEAR;
        endcase
    end

    // State, clear pointer and registered status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_CLEAR;
            ptr_r       <= '0;
            init_done_r <= 1'b0;
            collision_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            init_done_r <= (state_next_s == ST_READY);
            collision_r <= coll_s;
            if (state_r == ST_CLEAR) begin
                ptr_r <= ptr_r + PTR_ONE;
            end
        end
    end

    // Access acceptance, collision arbitration and read-data selection
    always_comb begin
        acc_a_s    = (state_r == ST_READY) && ena;
        acc_b_s    = (state_r == ST_READY) && enb;
        wr_a_s     = acc_a_s && wea;
        wr_b_s     = acc_b_s && web;
        coll_s     = wr_a_s && wr_b_s && (addra == addrb);
        keep_a_s   = wr_a_s && !(coll_s && B_WINS);
        keep_b_s   = wr_b_s && !(coll_s && !B_WINS);
        win_data_s = B_WINS ? dinb : dina;
        // Write-first returns what is actually stored, i.e. the winner on a collision
        if (WRITE_FRST && wr_a_s) begin
            rd_a_s = coll_s ? win_data_s : dina;
        end else begin
            rd_a_s = mem[addra];
        end
        if (WRITE_FRST && wr_b_s) begin
            rd_b_s = coll_s ? win_data_s : dinb;
        end else begin
            rd_b_s = mem[addrb];
        end
    end

    // Memory array: zeroed by the clear sequence, otherwise arbitrated user writes
    always_ff @(posedge clk) begin
        if (state_r == ST_CLEAR) begin
            mem[ptr_r[AW-1:0]] <= '0;
        end else begin
            if (keep_a_s) begin
                mem[addra] <= dina;
            end
            if (keep_b_s) begin
                mem[addrb] <= dinb;
            end
        end
    end

    dpram_rd_pipe #(.DW(DW), .OUT_REG(OUT_REG)) u_pipe_a (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (acc_a_s),
        .data  (rd_a_s),
        .dout  (douta),
        .valid (valida)
    );

    dpram_rd_pipe #(.DW(DW), .OUT_REG(OUT_REG)) u_pipe_b (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (acc_b_s),
        .data  (rd_b_s),
        .dout  (doutb),
        .valid (validb)
    );

    assign collision = collision_r;
    assign init_done = init_done_r;

endmodule

// File: tb/tb_dpram_param.sv
// Scoreboard bench for dpram_param: a default instance (8x16, read-first, A priority,
// 1-cycle) and a wide instance (32x64, write-first, B priority, 2-cycle).
module tb_dpram_param;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n0, ena0, wea0, enb0, web0, valida0, validb0, collision0, init_done0;
    logic [3:0]  addra0, addrb0;
    logic [7:0]  dina0, dinb0, douta0, doutb0;
    logic        rst_n1, ena1, wea1, enb1, web1, valida1, validb1, collision1, init_done1;
    logic [5:0]  addra1, addrb1;
    logic [31:0] dina1, dinb1, douta1, doutb1;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cnt   = 0;
    exp_t q0[$], q1[$], q2[$], q3[$], q4[$], q5[$];

    dpram_param #(.DW(8), .AW(4), .RD_MODE(0), .COLL_PRI(0), .OUT_REG(0)) u0 (
        .clk(clk), .rst_n(rst_n0),
        .ena(ena0), .wea(wea0), .addra(addra0), .dina(dina0), .douta(douta0), .valida(valida0),
        .enb(enb0), .web(web0), .addrb(addrb0), .dinb(dinb0), .doutb(doutb0), .validb(validb0),
        .collision(collision0), .init_done(init_done0)
    );

    dpram_param #(.DW(32), .AW(6), .RD_MODE(1), .COLL_PRI(1), .OUT_REG(1)) u1 (
        .clk(clk), .rst_n(rst_n1),
        .ena(ena1), .wea(wea1), .addra(addra1), .dina(dina1), .douta(douta1), .valida(valida1),
        .enb(enb1), .web(web1), .addrb(addrb1), .dinb(dinb1), .doutb(doutb1), .validb(validb1),
        .collision(collision1), .init_done(init_done1)
    );

    always @(posedge clk) cnt <= cnt + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic push(input int p, input logic [31:0] d, input int lat);
        exp_t e;
        e.data = d;
        e.due  = 32'(cnt + lat);
        case (p)
            0: q0.push_back(e);
            1: q1.push_back(e);
            2: q2.push_back(e);
            3: q3.push_back(e);
            4: q4.push_back(e);
            default: q5.push_back(e);
        endcase
    endtask

    function automatic int qsize(input int p);
        case (p)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            3: return q3.size();
            4: return q4.size();
            default: return q5.size();
        endcase
    endfunction

    task automatic mon(input int p, input logic v, input logic [31:0] d, input string nm);
        exp_t e;
        if (v) begin
            if (qsize(p) == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL %s unexpected output: got %h at cycle %0d, required none", nm, d, cnt);
            end else begin
                case (p)
                    0: e = q0.pop_front();
                    1: e = q1.pop_front();
                    2: e = q2.pop_front();
                    3: e = q3.pop_front();
                    4: e = q4.pop_front();
                    default: e = q5.pop_front();
                endcase
                if (p < 4) chk({nm, " data"}, d, e.data);
                chk({nm, " cycle"}, 32'(cnt), e.due);
            end
        end
    endtask

    // Monitor: every presented output must match the oldest expectation for that port
    always @(negedge clk) begin
        mon(0, valida0, 32'(douta0), "u0.a");
        mon(1, validb0, 32'(doutb0), "u0.b");
        mon(2, valida1, douta1, "u1.a");
        mon(3, validb1, doutb1, "u1.b");
        mon(4, collision0, 32'd0, "u0.collision");
        mon(5, collision1, 32'd0, "u1.collision");
    end

    task automatic idle();
        ena0 = 1'b0; wea0 = 1'b0; enb0 = 1'b0; web0 = 1'b0;
        ena1 = 1'b0; wea1 = 1'b0; enb1 = 1'b0; web1 = 1'b0;
    endtask

    // One cycle of stimulus on instance i with hand-computed read results xa/xb
    task automatic acc(input int i,
                       input logic ea, input logic wa, input int aa, input logic [31:0] da, input logic [31:0] xa,
                       input logic eb, input logic wb, input int ab, input logic [31:0] db, input logic [31:0] xb,
                       input logic xc);
        int lat;
        lat = (i == 0) ? 1 : 2;
        if (ea) push(2 * i, xa, lat);
        if (eb) push(2 * i + 1, xb, lat);
        if (xc) push(4 + i, 32'd0, 1);
        if (i == 0) begin
            ena0 = ea; wea0 = wa; addra0 = 4'(aa); dina0 = 8'(da);
            enb0 = eb; web0 = wb; addrb0 = 4'(ab); dinb0 = 8'(db);
        end else begin
            ena1 = ea; wea1 = wa; addra1 = 6'(aa); dina1 = da;
            enb1 = eb; web1 = wb; addrb1 = 6'(ab); dinb1 = db;
        end
        @(posedge clk); #1;
        idle();
    endtask

    // Count edges from reset release to init_done; instance 0 pokes its ports mid-clear
    task automatic wait_init(input int i, input int exp);
        int n;
        logic done;
        n = 0;
        done = 1'b0;
        while (n < 200 && !done) begin
            if (i == 0) begin
                ena0 = (n == 3); enb0 = (n == 3); addra0 = 4'd2; addrb0 = 4'd5;
            end
            @(posedge clk); #1;
            n++;
            done = (i == 0) ? init_done0 : init_done1;
        end
        idle();
        chk($sformatf("u%0d init_done latency", i), 32'(n), 32'(exp));
    endtask

    initial begin
        logic [31:0] f;
        int left;
        rst_n0 = 1'b0; rst_n1 = 1'b0;
        addra0 = 4'd0; addrb0 = 4'd0; dina0 = 8'd0; dinb0 = 8'd0;
        addra1 = 6'd0; addrb1 = 6'd0; dina1 = 32'd0; dinb1 = 32'd0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("u0 reset douta", 32'(douta0), 32'd0);
        chk("u0 reset valida", 32'(valida0), 32'd0);
        chk("u0 reset collision", 32'(collision0), 32'd0);
        chk("u0 reset init_done", 32'(init_done0), 32'd0);
        chk("u1 reset doutb", doutb1, 32'd0);
        chk("u1 reset init_done", 32'(init_done1), 32'd0);

        // Reset in the middle of the clear sequence restarts it
        rst_n0 = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst_n0 = 1'b0;
        #1;
        chk("u0 midclear init_done", 32'(init_done0), 32'd0);
        chk("u0 midclear validb", 32'(validb0), 32'd0);
        @(posedge clk); #1;
        rst_n0 = 1'b1;
        wait_init(0, 16);

        // Cleared contents read back as zero from alternating ports
        for (int a = 0; a < 16; a++) begin
            acc(0, (a % 2) == 0, 1'b0, a, 32'd0, 32'd0, (a % 2) == 1, 1'b0, a, 32'd0, 32'd0, 1'b0);
        end

        // Basic write on A, read on B
        acc(0, 1'b1, 1'b1, 3, 32'h5A, 32'h00, 1'b0, 1'b0, 0, 32'd0, 32'd0, 1'b0);
        acc(0, 1'b0, 1'b0, 0, 32'd0, 32'd0, 1'b1, 1'b0, 3, 32'd0, 32'h5A, 1'b0);

        // Read-first: same port sees old data, other port also sees old data
        acc(0, 1'b1, 1'b1, 7, 32'h11, 32'h00, 1'b0, 1'b0, 0, 32'd0, 32'd0, 1'b0);
        acc(0, 1'b1, 1'b1, 7, 32'h22, 32'h11, 1'b1, 1'b0, 7, 32'd0, 32'h11, 1'b0);
        acc(0, 1'b1, 1'b0, 7, 32'd0, 32'h22, 1'b0, 1'b0, 0, 32'd0, 32'd0, 1'b0);

        // Same-address collision, A wins
        acc(0, 1'b1, 1'b1, 9, 32'hAA, 32'h00, 1'b1, 1'b1, 9, 32'hBB, 32'h00, 1'b1);
        acc(0, 1'b1, 1'b0, 9, 32'd0, 32'hAA, 1'b1, 1'b0, 9, 32'd0, 32'hAA, 1'b0);
        @(posedge clk); #1;
        chk("u0 douta hold", 32'(douta0), 32'hAA);
        chk("u0 valida idle", 32'(valida0), 32'd0);

        // Different addresses / single writer on a shared address: no collision
        acc(0, 1'b1, 1'b1, 10, 32'h01, 32'h00, 1'b1, 1'b1, 11, 32'h02, 32'h00, 1'b0);
        acc(0, 1'b1, 1'b0, 11, 32'd0, 32'h02, 1'b1, 1'b0, 10, 32'd0, 32'h01, 1'b0);
        acc(0, 1'b1, 1'b1, 12, 32'h33, 32'h00, 1'b1, 1'b0, 12, 32'd0, 32'h00, 1'b0);

        // Wide instance: 64-location clear, then full write/readback sweep
        rst_n1 = 1'b1;
        wait_init(1, 64);
        for (int a = 0; a < 64; a++) begin
            f = 32'hA5000000 ^ (32'(a) * 32'h00010203);
            acc(1, (a % 2) == 0, (a % 2) == 0, a, f, f, (a % 2) == 1, (a % 2) == 1, a, f, f, 1'b0);
        end
        for (int a = 0; a < 64; a++) begin
            f = 32'hA5000000 ^ (32'(a) * 32'h00010203);
            acc(1, (a % 2) == 1, 1'b0, a, 32'd0, f, (a % 2) == 0, 1'b0, a, 32'd0, f, 1'b0);
        end

        // Write-first: same port sees new data, cross port sees old data
        acc(1, 1'b1, 1'b1, 3, 32'h5A, 32'h5A, 1'b0, 1'b0, 0, 32'd0, 32'd0, 1'b0);
        acc(1, 1'b0, 1'b0, 0, 32'd0, 32'd0, 1'b1, 1'b0, 3, 32'd0, 32'h5A, 1'b0);
        acc(1, 1'b1, 1'b1, 7, 32'h11, 32'h11, 1'b0, 1'b0, 0, 32'd0, 32'd0, 1'b0);
        acc(1, 1'b1, 1'b1, 7, 32'h22, 32'h22, 1'b1, 1'b0, 7, 32'd0, 32'h11, 1'b0);

        // Collision with B priority: both write-first reads return B's data
        acc(1, 1'b1, 1'b1, 9, 32'hAA, 32'hBB, 1'b1, 1'b1, 9, 32'hBB, 32'hBB, 1'b1);
        acc(1, 1'b1, 1'b0, 9, 32'd0, 32'hBB, 1'b0, 1'b0, 0, 32'd0, 32'd0, 1'b0);
        acc(1, 1'b1, 1'b1, 10, 32'h01, 32'h01, 1'b1, 1'b1, 11, 32'h02, 32'h02, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        left = q0.size() + q1.size() + q2.size() + q3.size() + q4.size() + q5.size();
        chk("outstanding expectations", 32'(left), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dpram_param.md
Name: dpram_param

Overview:
Parametrised true dual-port synchronous RAM. It is the next generation of the team's 16x8 dual-port memory. Both ports can read and write; widths and depth are generic, and read latency is selectable. It adds an explicit read-during-write mode, a write-collision priority rule with a flag, a per-port read-valid, and a hardware clear sequence that zeroes the memory after reset. It is used as a generic buffer/scratchpad between two independent requesters in the same clock domain.

Parameters:
DW, 8, data width in bits (>=1)
AW, 4, address width; DEPTH = 2**AW locations
RD_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new data)
COLL_PRI, 0, simultaneous same-address write winner: 0 = port A, 1 = port B
OUT_REG, 0, 0 = 1-cycle read latency; 1 = extra output register, 2-cycle latency

Ports:
clk  in  1  single clock, all logic on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
ena  in  1  port A access enable
wea  in  1  port A write enable (effective only with ena)
addra  in  AW  port A address
dina  in  DW  port A write data
douta  out  DW  port A read data
valida  out  1  douta holds the result of an accepted port-A access
enb, web, addrb, dinb, doutb, validb  as port A, for port B
collision  out  1  one-cycle pulse: both ports wrote the same address in the same cycle
init_done  out  1  high once the clear sequence has finished

Behaviour:
- Reset (rst_n low, async): douta/doutb = 0, valida/validb = 0, collision = 0, init_done = 0. FSM goes to CLEAR with clear pointer = 0. Memory contents are not reset directly; the clear sequence zeroes them.
- FSM state CLEAR: writes 0 to mem[ptr] and increments ptr each cycle.
- CLEAR -> READY in the cycle ptr = DEPTH-1 is written. init_done goes high on the next edge, DEPTH cycles after the first clk edge with rst_n high.
- While in CLEAR: ena/enb are ignored, no user writes occur, and valida/validb stay 0.
- Reset asserted mid-clear or mid-operation restarts CLEAR from ptr 0.
- READY is terminal until the next reset.
- In READY, an access is accepted when ena=1. If wea=1, dina is written to mem[addra]. Every accepted access also reads.
- Read latency with OUT_REG=0: douta/valida update on the edge that samples the access (data visible the following cycle).
- Read latency with OUT_REG=1: one further cycle; both data and valid are pipelined.
- valida = 0 for cycles with no accepted access. douta holds its last value when not valid; it does not return to 0.
- Same-port read-during-write: RD_MODE=0 returns the old contents; RD_MODE=1 returns the value actually stored that cycle.
- Cross-port read of an address the other port writes in the same cycle always returns the old contents.
- Both ports write the same address in the same cycle:
  - The COLL_PRI winner's data is stored; the loser's write is dropped.
  - collision pulses high for exactly one cycle, on the same edge as the write.
  - A write-first read on either port returns the winner's data.
- Same address, only one port writing: not a collision; collision stays 0.
- Address arithmetic: the clear pointer is AW+1 bits wide to detect termination; the memory index uses its low AW bits. There is no address wrap logic for user ports because addresses are always in range.

Decomposition:
- Shared package dpram_pkg: FSM state enum (ST_CLEAR, ST_READY), RD_FIRST/WR_FIRST and PRI_A/PRI_B constants.
- One natural sub-module: dpram_rd_pipe, the per-port read data/valid register stage parametrised by OUT_REG. It is instantiated twice.
- Memory array, write arbitration and the clear FSM stay in the top module.

Test Plan:
- Clear sequence: release reset with the default parameters. init_done must rise 16 cycles after release. Reading every address must return 0x00 with valid=1 one cycle later. ena pulsed during CLEAR must produce no valid.
- Basic R/W: A writes 0x5A to addr 3; B reads addr 3 next cycle. doutb = 0x5A with validb=1 one cycle later (two cycles later with OUT_REG=1).
- Read-during-write: mem[7]=0x11; A writes 0x22 to addr 7 with ena=1. douta = 0x11 when RD_MODE=0 and 0x22 when RD_MODE=1. B reading addr 7 in the same cycle gets 0x11 in both modes.
- Collision: A writes 0xAA and B writes 0xBB to addr 9 in the same cycle. collision pulses for 1 cycle. A later read returns 0xAA when COLL_PRI=0 and 0xBB when COLL_PRI=1. A and B writing different addresses gives collision=0.
- Reset mid-clear: assert rst_n low at clear cycle 5. Outputs go to 0 immediately; after release, init_done takes a full 16 cycles again.
- Width/depth sweep: with DW=32, AW=6, perform a write then readback of all 64 locations from alternating ports. The data must match, and init_done must appear after 64 cycles.
